// File: rtl/aes_subbytes_sched_pkg.sv
// Shared types and constants for the SubBytes scheduler.
// The round-robin build option (AES_SBSCHED_RR_EN) lives in the arbiter.
package aes_subbytes_sched_pkg;

  localparam int unsigned AesCols   = 4;
  localparam int unsigned AesWordW  = 32;
  localparam int unsigned AesStateW = 128;
  localparam int unsigned ColW      = $clog2(AesCols);

  typedef enum logic [2:0] {
    StIdle,
    StStRun,
    StKsRun,
    StStDone,
    StKsDone
  } sched_state_e;

  // Column 0 is the most significant word of the state.
  function automatic logic [AesWordW-1:0] get_col(input logic [AesStateW-1:0] s,
                                                  input logic [ColW-1:0]      idx);
    return s[{~idx, 5'd0} +: AesWordW];
  endfunction

endpackage

// File: rtl/aes_subbytes_sched_arb.sv
// Two-way grant logic for the SubBytes scheduler.
// AES_SBSCHED_RR_EN selects round-robin with a pointer register; otherwise fixed priority.
module aes_subbytes_sched_arb #(
  parameter int unsigned KS_PRIORITY = 1
) (
`ifdef AES_SBSCHED_RR_EN
  input  logic clk_i,
  input  logic rst_ni,
`endif
  input  logic en_i,
  input  logic st_valid_i,
  input  logic ks_valid_i,
  output logic st_gnt_o,
  output logic ks_gnt_o
);

  logic ks_favoured;

`ifdef AES_SBSCHED_RR_EN
  logic ptr_q;  // 1: key schedule wins the next tie
  logic unused_ks_prio;

  assign unused_ks_prio = ^KS_PRIORITY;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b1;
    end else if (st_gnt_o) begin
      ptr_q <= 1'b1;
    end else if (ks_gnt_o) begin
      ptr_q <= 1'b0;
    end
  end

  assign ks_favoured = ptr_q;
`else
  assign ks_favoured = (KS_PRIORITY != 0);
`endif

  assign ks_gnt_o = en_i & ks_valid_i & (ks_favoured | ~st_valid_i);
  assign st_gnt_o = en_i & st_valid_i & ~ks_gnt_o;

endmodule

// File: rtl/aes_subbytes_sched.sv
// Shares one external 32-bit SubBytes unit between the round datapath and key expansion.
// Build option AES_SBSCHED_RR_EN enables round-robin arbitration on simultaneous requests.
module aes_subbytes_sched
  import aes_subbytes_sched_pkg::*;
#(
  parameter int unsigned SB_PIPE     = 1,
  parameter int unsigned KS_PRIORITY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st_req_valid,
  output logic                 st_req_ready,
  input  logic [AesStateW-1:0] st_req_data,
  input  logic                 st_req_enc_dec,
  output logic                 st_rsp_valid,
  input  logic                 st_rsp_ready,
  output logic [AesStateW-1:0] st_rsp_data,
  input  logic                 ks_req_valid,
  output logic                 ks_req_ready,
  input  logic [AesWordW-1:0]  ks_req_word,
  output logic                 ks_rsp_valid,
  input  logic                 ks_rsp_ready,
  output logic [AesWordW-1:0]  ks_rsp_word,
  output logic [AesWordW-1:0]  sb_data_in,
  output logic                 sb_enc_dec,
  input  logic [AesWordW-1:0]  sb_data_out,
  output logic                 busy
);

  localparam logic [ColW-1:0] LastCol = ColW'(AesCols - 1);

  sched_state_e         state_q;
  logic [ColW-1:0]      iss_cnt_q, cap_cnt_q;
  logic                 iss_done_q, iss_vld_q, enc_q;
  logic [AesStateW-1:0] req_q, st_buf_q;
  logic [AesWordW-1:0]  ks_buf_q;
  logic                 idle, iss_en, cap_en;

  assign idle   = (state_q == StIdle);
  assign iss_en = ((state_q == StStRun) || (state_q == StKsRun)) && !iss_done_q;
  // The external unit returns data SB_PIPE cycles after issue.
  assign cap_en = (SB_PIPE == 0) ? iss_en : iss_vld_q;

  aes_subbytes_sched_arb #(
    .KS_PRIORITY(KS_PRIORITY)
  ) u_arb (
`ifdef AES_SBSCHED_RR_EN
    .clk_i     (clk),
    .rst_ni    (rst_n),
`endif
    .en_i      (idle),
    .st_valid_i(st_req_valid),
    .ks_valid_i(ks_req_valid),
    .st_gnt_o  (st_req_ready),
    .ks_gnt_o  (ks_req_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      iss_cnt_q  <= '0;
      cap_cnt_q  <= '0;
      iss_done_q <= 1'b0;
      iss_vld_q  <= 1'b0;
      enc_q      <= 1'b1;
      req_q      <= '0;
      st_buf_q   <= '0;
      ks_buf_q   <= '0;
    end else begin
      iss_vld_q <= iss_en;
      if (iss_en) iss_cnt_q <= iss_cnt_q + ColW'(1);
      unique case (state_q)
        StIdle: begin
          iss_cnt_q  <= '0;
          cap_cnt_q  <= '0;
          iss_done_q <= 1'b0;
          if (ks_req_ready) begin
            // Key word sits in column 0 so the shared issue path handles both.
            req_q   <= {ks_req_word, {(AesStateW - AesWordW){1'b0}}};
            enc_q   <= 1'b1;
            state_q <= StKsRun;
          end else if (st_req_ready) begin
            req_q   <= st_req_data;
            enc_q   <= st_req_enc_dec;
            state_q <= StStRun;
          end
        end
        StStRun: begin
          if (iss_en && (iss_cnt_q == LastCol)) iss_done_q <= 1'b1;
          if (cap_en) begin
            st_buf_q[{~cap_cnt_q, 5'd0} +: AesWordW] <= sb_data_out;
            cap_cnt_q <= cap_cnt_q + ColW'(1);
            if (cap_cnt_q == LastCol) state_q <= StStDone;
          end
        end
        StKsRun: begin
          if (iss_en) iss_done_q <= 1'b1;
          if (cap_en) begin
            ks_buf_q <= sb_data_out;
            state_q  <= StKsDone;
          end
        end
        StStDone: begin
          if (st_rsp_ready) begin
            st_buf_q <= '0;
            state_q  <= StIdle;
          end
        end
        StKsDone: begin
          if (ks_rsp_ready) begin
            ks_buf_q <= '0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign st_rsp_valid = (state_q == StStDone);
  assign ks_rsp_valid = (state_q == StKsDone);
  assign st_rsp_data  = st_buf_q;
  assign ks_rsp_word  = ks_buf_q;
  assign sb_data_in   = iss_en ? get_col(req_q, iss_cnt_q) : '0;
  assign sb_enc_dec   = (iss_en && (state_q == StStRun)) ? enc_q : 1'b1;
  assign busy         = !idle;

endmodule

// File: tb/tb_aes_subbytes_sched.sv
// Self-checking bench for aes_subbytes_sched with a LUT SubBytes model and scoreboard.
// Build with or without AES_SBSCHED_RR_EN; override SB_PIPE/KS_PRIORITY as needed.
module tb_aes_subbytes_sched;
  parameter int unsigned SB_PIPE     = 1;
  parameter int unsigned KS_PRIORITY = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         st_req_valid = 1'b0, st_req_ready, st_req_enc_dec = 1'b1;
  logic [127:0] st_req_data = '0, st_rsp_data;
  logic         st_rsp_valid, st_rsp_ready = 1'b1;
  logic         ks_req_valid = 1'b0, ks_req_ready, ks_rsp_valid, ks_rsp_ready = 1'b1;
  logic [31:0]  ks_req_word = '0, ks_rsp_word;
  logic [31:0]  sb_data_in, sb_data_out, sb_comb, sb_pipe_q;
  logic         sb_enc_dec, busy;

  always #5 clk = ~clk;

  aes_subbytes_sched #(
    .SB_PIPE    (SB_PIPE),
    .KS_PRIORITY(KS_PRIORITY)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .st_req_valid  (st_req_valid),
    .st_req_ready  (st_req_ready),
    .st_req_data   (st_req_data),
    .st_req_enc_dec(st_req_enc_dec),
    .st_rsp_valid  (st_rsp_valid),
    .st_rsp_ready  (st_rsp_ready),
    .st_rsp_data   (st_rsp_data),
    .ks_req_valid  (ks_req_valid),
    .ks_req_ready  (ks_req_ready),
    .ks_req_word   (ks_req_word),
    .ks_rsp_valid  (ks_rsp_valid),
    .ks_rsp_ready  (ks_rsp_ready),
    .ks_rsp_word   (ks_rsp_word),
    .sb_data_in    (sb_data_in),
    .sb_enc_dec    (sb_enc_dec),
    .sb_data_out   (sb_data_out),
    .busy          (busy)
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int st_acc_cyc = 0, ks_acc_cyc = 0;
  int first_id = -1;  // 0: state, 1: key
  bit ptr_m = 1'b1;   // round-robin model: 1 means key wins the next tie
  logic [127:0] st_exp_q[$];
  logic [31:0]  ks_exp_q[$];
  logic [7:0]   fwd_t[256], inv_t[256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // GF(2^8) arithmetic for building the S-box tables.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w, input logic enc);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = enc ? fwd_t[w[8*i +: 8]] : inv_t[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] d, input logic enc);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = sub_word(d[127 - 32*c -: 32], enc);
    return r;
  endfunction

  // External SubBytes unit model.
  always_comb sb_comb = sub_word(sb_data_in, sb_enc_dec);
  always @(posedge clk) sb_pipe_q <= sb_comb;
  assign sb_data_out = (SB_PIPE == 0) ? sb_comb : sb_pipe_q;

  // Response monitor: first-valid latency and scoreboard pops on handshake.
  logic st_v_prev = 1'b0, ks_v_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      st_v_prev <= 1'b0;
      ks_v_prev <= 1'b0;
    end else begin
      if (st_rsp_valid && !st_v_prev) check_eq("st_lat", cyc - st_acc_cyc, 4 + SB_PIPE);
      if (ks_rsp_valid && !ks_v_prev) check_eq("ks_lat", cyc - ks_acc_cyc, 1 + SB_PIPE);
      if (st_rsp_valid && st_rsp_ready) begin
        if (st_exp_q.size() == 0) check_eq("st_unexpected_rsp", st_rsp_valid, 0);
        else check_eq("st_data", st_rsp_data, st_exp_q.pop_front());
      end
      if (ks_rsp_valid && ks_rsp_ready) begin
        if (ks_exp_q.size() == 0) check_eq("ks_unexpected_rsp", ks_rsp_valid, 0);
        else check_eq("ks_word", ks_rsp_word, ks_exp_q.pop_front());
      end
      st_v_prev <= st_rsp_valid;
      ks_v_prev <= ks_rsp_valid;
    end
  end

  task automatic send_st(input logic [127:0] d, input logic enc, input logic [127:0] exp);
    int n = 0;
    @(posedge clk); #1;
    st_req_data = d; st_req_enc_dec = enc; st_req_valid = 1'b1;
    @(negedge clk);
    while (!st_req_ready && n < 200) begin @(negedge clk); n++; end
    if (!st_req_ready) begin
      check_eq("st_accept_timeout", st_req_ready, 1);
      st_req_valid = 1'b0;
      return;
    end
    st_exp_q.push_back(exp);
    st_acc_cyc = cyc + 1;
    if (first_id < 0) first_id = 0;
    ptr_m = 1'b1;
    @(posedge clk); #1;
    st_req_valid = 1'b0; st_req_data = ~d; st_req_enc_dec = ~enc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("st_issue_col%0d", i), sb_data_in, d[127 - 32*i -: 32]);
      check_eq($sformatf("st_issue_enc%0d", i), sb_enc_dec, enc);
    end
  endtask

  task automatic send_ks(input logic [31:0] w, input logic [31:0] exp);
    int n = 0;
    @(posedge clk); #1;
    ks_req_word = w; ks_req_valid = 1'b1;
    @(negedge clk);
    while (!ks_req_ready && n < 200) begin @(negedge clk); n++; end
    if (!ks_req_ready) begin
      check_eq("ks_accept_timeout", ks_req_ready, 1);
      ks_req_valid = 1'b0;
      return;
    end
    ks_exp_q.push_back(exp);
    ks_acc_cyc = cyc + 1;
    if (first_id < 0) first_id = 1;
    ptr_m = 1'b0;
    @(posedge clk); #1;
    ks_req_valid = 1'b0; ks_req_word = ~w;
    @(negedge clk);
    check_eq("ks_issue_word", sb_data_in, w);
    check_eq("ks_issue_enc", sb_enc_dec, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || st_exp_q.size() != 0 || ks_exp_q.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    check_eq("drain_busy", busy, 0);
  endtask

  initial begin
    logic [127:0] d, exp;
    logic [31:0]  w;
    logic         enc;
    int           exp_first, n;

    for (int i = 0; i < 256; i++) fwd_t[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

    repeat (3) @(negedge clk);
    check_eq("rst_st_req_ready", st_req_ready, 0);
    check_eq("rst_ks_req_ready", ks_req_ready, 0);
    check_eq("rst_st_rsp_valid", st_rsp_valid, 0);
    check_eq("rst_ks_rsp_valid", ks_rsp_valid, 0);
    check_eq("rst_st_rsp_data", st_rsp_data, 0);
    check_eq("rst_ks_rsp_word", ks_rsp_word, 0);
    check_eq("rst_sb_data_in", sb_data_in, 0);
    check_eq("rst_sb_enc_dec", sb_enc_dec, 1);
    check_eq("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    send_st(128'h00010203_00010203_53535353_00000000, 1'b1,
            128'h637c777b_637c777b_edededed_63636363);
    send_st(128'h63636363_7c7c7c7c_edededed_63636363, 1'b0,
            128'h00000000_01010101_53535353_00000000);
    send_ks(32'h09010203, 32'h017c777b);

    for (int k = 0; k < 3; k++) begin
      d   = {$urandom, $urandom, $urandom, $urandom};
      enc = 1'($urandom_range(0, 1));
      send_st(d, enc, sub_state(d, enc));
      w = $urandom;
      send_ks(w, sub_word(w, 1'b1));
    end

    // Simultaneous requests.
    for (int k = 0; k < 4; k++) begin
      wait_idle();
      d = {$urandom, $urandom, $urandom, $urandom};
      w = $urandom;
`ifdef AES_SBSCHED_RR_EN
      exp_first = ptr_m ? 1 : 0;
`else
      exp_first = (KS_PRIORITY != 0) ? 1 : 0;
`endif
      first_id = -1;
      fork
        send_st(d, 1'b1, sub_state(d, 1'b1));
        send_ks(w, sub_word(w, 1'b1));
      join
      check_eq($sformatf("tie_first%0d", k), first_id, exp_first);
    end

    // Response back-pressure with a pending key request.
    wait_idle();
    @(posedge clk); #1 st_rsp_ready = 1'b0;
    d   = {$urandom, $urandom, $urandom, $urandom};
    exp = sub_state(d, 1'b1);
    send_st(d, 1'b1, exp);
    n = 0;
    @(negedge clk);
    while (!st_rsp_valid && n < 50) begin @(negedge clk); n++; end
    w = $urandom;
    @(posedge clk); #1;
    ks_req_word = w; ks_req_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("hold_valid", st_rsp_valid, 1);
      check_eq("hold_data", st_rsp_data, exp);
      check_eq("hold_ks_ready", ks_req_ready, 0);
    end
    @(posedge clk); #1 st_rsp_ready = 1'b1;
    fork
      send_ks(w, sub_word(w, 1'b1));
      begin
        @(negedge clk);
        @(negedge clk);
        check_eq("idle_after_rsp", busy, 0);
      end
    join

    // Reset while column 2 is on the bus.
    wait_idle();
    d = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    st_req_data = d; st_req_enc_dec = 1'b1; st_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!st_req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 st_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_col2", sb_data_in, d[63:32]);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_sb_data_in", sb_data_in, 0);
    check_eq("mid_rst_sb_enc_dec", sb_enc_dec, 1);
    check_eq("mid_rst_st_rsp_data", st_rsp_data, 0);
    ptr_m = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("mid_rst_no_rsp", st_rsp_valid, 0);
    end
    send_st(128'h00010203_00010203_53535353_00000000, 1'b1,
            128'h637c777b_637c777b_edededed_63636363);

    wait_idle();
    check_eq("st_queue_left", st_exp_q.size(), 0);
    check_eq("ks_queue_left", ks_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
